// File: rtl/stream_mux_nto1.sv
// Registered N-to-1 valid/ready stream multiplexer with fixed-select or round-robin grant.
// One-cycle latency, full throughput. The new beat may replace the held one in the same cycle.
module stream_mux_nto1 #(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [$clog2(N)-1:0]      sel,
  input  logic [N-1:0]              in_valid,
  input  logic [N*WIDTH-1:0]        in_data,
  output logic [N-1:0]              in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [$clog2(N)-1:0]      out_chan,
  input  logic                      out_ready
);

  localparam int CW = $clog2(N);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [CW-1:0]    r_out_chan;
  logic [CW-1:0]    r_ptr;

  logic             w_load_en;
  logic             w_fix_found;
  logic             w_rr_found;
  logic [CW-1:0]    w_rr_grant;
  logic [CW-1:0]    w_scan_idx;
  logic             w_grant_found;
  logic [CW-1:0]    w_grant;
  logic [N-1:0]     w_ready;
  logic             w_xfer;
  logic [WIDTH-1:0] w_ch_data [N];

  for (genvar i = 0; i < N; i++) begin : g_split
    assign w_ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  assign w_load_en   = !r_out_valid || out_ready;
  assign w_fix_found = (int'(sel) < N);

  // Round-robin scan: first valid channel after the last granted one, wrapping modulo N.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_grant = '0;
    w_scan_idx = '0;
    for (int k = 1; k <= N; k++) begin
      w_scan_idx = CW'((int'(r_ptr) + k) % N);
      if (!w_rr_found && in_valid[w_scan_idx]) begin
        w_rr_found = 1'b1;
        w_rr_grant = w_scan_idx;
      end else begin
        w_rr_found = w_rr_found;
      end
    end
  end

  // Grant and ready; reset forces every ready low so no handshake slips through.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant       = '0;
    w_ready       = '0;
    if (mode) begin
      w_grant_found = w_rr_found;
      w_grant       = w_rr_grant;
    end else begin
      w_grant_found = w_fix_found;
      w_grant       = sel;
    end
    if (w_grant_found && w_load_en && !rst) begin
      w_ready[w_grant] = 1'b1;
    end else begin
      w_ready = '0;
    end
  end

  assign w_xfer = w_grant_found && w_load_en && in_valid[w_grant];

  // Output register and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_ptr       <= CW'(N - 1);
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_ch_data[w_grant];
      r_out_chan  <= w_grant;
      if (mode) begin
        r_ptr <= w_grant;
      end
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;

endmodule
